// File: rtl/udma_hyper_cfg_queue.sv
// Per-channel HyperBus config banks plus a shared descriptor FIFO.
// A kick on RXCFG/TXCFG snapshots the channel bank into the FIFO for the transaction controller.
module udma_hyper_cfg_queue #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int NB_CH          = 2,
  parameter int QUEUE_DEPTH    = 4,
  localparam int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1,
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [31:0]               cfg_data_i,
  input  logic [5+CH_W-1:0]         cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_reg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic [NB_CH-1:0]          cfg_rx_clr_o,
  output logic [NB_CH-1:0]          cfg_tx_clr_o,
  output logic [15:0]               cfg_hyper_intreg_o,
  output logic                      trans_valid_o,
  input  logic                      trans_ready_i,
  output logic [CH_W-1:0]           trans_ch_o,
  output logic                      trans_rwn_o,
  output logic                      trans_addr_space_o,
  output logic                      trans_burst_o,
  output logic [31:0]               trans_hyper_addr_o,
  output logic [L2_AWIDTH_NOAL-1:0] trans_l2_addr_o,
  output logic [TRANS_SIZE-1:0]     trans_size_o,
  output logic [2+4*TRANS_SIZE-1:0] trans_twd_o,
  input  logic                      busy_i
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int TWD_W = 2 + 4*TRANS_SIZE;

  localparam logic [4:0] REG_RX_SADDR   = 5'h00;
  localparam logic [4:0] REG_RX_SIZE    = 5'h01;
  localparam logic [4:0] REG_RXCFG      = 5'h02;
  localparam logic [4:0] REG_TX_SADDR   = 5'h03;
  localparam logic [4:0] REG_TX_SIZE    = 5'h04;
  localparam logic [4:0] REG_TXCFG      = 5'h05;
  localparam logic [4:0] REG_CA_SETUP   = 5'h06;
  localparam logic [4:0] REG_HYPER_ADDR = 5'h07;
  localparam logic [4:0] REG_HYPER_CFG  = 5'h08;
  localparam logic [4:0] REG_STATUS     = 5'h09;
  localparam logic [4:0] REG_EXT_ACT    = 5'h0A;
  localparam logic [4:0] REG_EXT_CNT    = 5'h0B;
  localparam logic [4:0] REG_EXT_STR    = 5'h0C;
  localparam logic [4:0] REG_L2_ACT     = 5'h0D;
  localparam logic [4:0] REG_L2_CNT     = 5'h0E;
  localparam logic [4:0] REG_L2_STR     = 5'h0F;

  typedef struct packed {
    logic [CH_W-1:0]           ch;
    logic                      rwn;
    logic                      space;
    logic                      burst;
    logic [31:0]               haddr;
    logic [L2_AWIDTH_NOAL-1:0] l2;
    logic [TRANS_SIZE-1:0]     size;
    logic [TWD_W-1:0]          twd;
  } desc_t;

  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q   [NB_CH];
  logic [TRANS_SIZE-1:0]     rx_size_q    [NB_CH];
  logic [L2_AWIDTH_NOAL-1:0] tx_saddr_q   [NB_CH];
  logic [TRANS_SIZE-1:0]     tx_size_q    [NB_CH];
  logic [1:0]                ca_setup_q   [NB_CH];
  logic [31:0]               hyper_addr_q [NB_CH];
  logic                      ext_act_q    [NB_CH];
  logic [TRANS_SIZE-1:0]     ext_cnt_q    [NB_CH];
  logic [TRANS_SIZE-1:0]     ext_str_q    [NB_CH];
  logic                      l2_act_q     [NB_CH];
  logic [TRANS_SIZE-1:0]     l2_cnt_q     [NB_CH];
  logic [TRANS_SIZE-1:0]     l2_str_q     [NB_CH];
  logic [CNT_W-1:0]          rx_pend_q    [NB_CH];
  logic [CNT_W-1:0]          tx_pend_q    [NB_CH];
  logic [15:0]               hyper_cfg_q;

  desc_t             fifo_q [QUEUE_DEPTH];
  desc_t             push_desc;
  desc_t             head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              valid_q, ovf_q;
  logic [NB_CH-1:0]  rx_clr_q, tx_clr_q;
  logic [NB_CH-1:0]  rx_inc, rx_dec, tx_inc, tx_dec;

  logic [4:0]        reg_off;
  logic [CH_W-1:0]   reg_ch, ch_idx;
  logic              ch_ok, wr_en, rx_cfg_wr, tx_cfg_wr, status_wr;
  logic              kick, push, pop, drop, flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign reg_off   = cfg_addr_i[4:0];
  assign reg_ch    = cfg_addr_i[5 +: CH_W];
  assign ch_ok     = int'(reg_ch) < NB_CH;
  assign ch_idx    = ch_ok ? reg_ch : '0;
  assign wr_en     = cfg_valid_i & ~cfg_reg_rwn_i;
  assign rx_cfg_wr = wr_en & ch_ok & (reg_off == REG_RXCFG);
  assign tx_cfg_wr = wr_en & ch_ok & (reg_off == REG_TXCFG);
  assign status_wr = wr_en & (reg_off == REG_STATUS);
  assign flush     = status_wr & cfg_data_i[30];
  assign kick      = (rx_cfg_wr | tx_cfg_wr) & cfg_data_i[4];
  assign pop       = valid_q & trans_ready_i;
  // A full FIFO still takes a kick when the head leaves in the same cycle.
  assign push      = kick & ((count_q < CNT_W'(QUEUE_DEPTH)) | pop);
  assign drop      = kick & ~push;

  always_comb begin
    push_desc       = '0;
    push_desc.ch    = ch_idx;
    push_desc.rwn   = rx_cfg_wr;
    push_desc.space = ca_setup_q[ch_idx][1];
    push_desc.burst = ca_setup_q[ch_idx][0];
    push_desc.haddr = hyper_addr_q[ch_idx];
    push_desc.l2    = rx_cfg_wr ? rx_saddr_q[ch_idx] : tx_saddr_q[ch_idx];
    push_desc.size  = rx_cfg_wr ? rx_size_q[ch_idx]  : tx_size_q[ch_idx];
    push_desc.twd   = {ext_act_q[ch_idx], ext_cnt_q[ch_idx], ext_str_q[ch_idx],
                       l2_act_q[ch_idx],  l2_cnt_q[ch_idx],  l2_str_q[ch_idx]};
  end

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CH; c++) begin
        rx_saddr_q[c]   <= '0;
        rx_size_q[c]    <= '0;
        tx_saddr_q[c]   <= '0;
        tx_size_q[c]    <= '0;
        ca_setup_q[c]   <= 2'b01;
        hyper_addr_q[c] <= '0;
        ext_act_q[c]    <= 1'b0;
        ext_cnt_q[c]    <= '0;
        ext_str_q[c]    <= '0;
        l2_act_q[c]     <= 1'b0;
        l2_cnt_q[c]     <= '0;
        l2_str_q[c]     <= '0;
      end
      hyper_cfg_q <= '0;
    end else if (wr_en) begin
      if (reg_off == REG_HYPER_CFG) hyper_cfg_q <= cfg_data_i[15:0];
      if (ch_ok) begin
        case (reg_off)
          REG_RX_SADDR:   rx_saddr_q[ch_idx]   <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_RX_SIZE:    rx_size_q[ch_idx]    <= cfg_data_i[TRANS_SIZE-1:0];
          REG_TX_SADDR:   tx_saddr_q[ch_idx]   <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_TX_SIZE:    tx_size_q[ch_idx]    <= cfg_data_i[TRANS_SIZE-1:0];
          REG_CA_SETUP:   ca_setup_q[ch_idx]   <= cfg_data_i[1:0];
          REG_HYPER_ADDR: hyper_addr_q[ch_idx] <= cfg_data_i;
          REG_EXT_ACT:    ext_act_q[ch_idx]    <= cfg_data_i[0];
          REG_EXT_CNT:    ext_cnt_q[ch_idx]    <= cfg_data_i[TRANS_SIZE-1:0];
          REG_EXT_STR:    ext_str_q[ch_idx]    <= cfg_data_i[TRANS_SIZE-1:0];
          REG_L2_ACT:     l2_act_q[ch_idx]     <= cfg_data_i[0];
          REG_L2_CNT:     l2_cnt_q[ch_idx]     <= cfg_data_i[TRANS_SIZE-1:0];
          REG_L2_STR:     l2_str_q[ch_idx]     <= cfg_data_i[TRANS_SIZE-1:0];
          default: ;
        endcase
      end
    end
  end

  // Flush wins over any push/pop in the same cycle; overflow is sticky until cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        valid_q  <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= push_desc;
          wr_ptr_q         <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_nxt;
        valid_q <= (count_nxt != '0);
      end
      if (status_wr && cfg_data_i[31]) ovf_q <= 1'b0;
      else if (drop)                   ovf_q <= 1'b1;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      rx_inc[c] = push & push_desc.rwn  & (push_desc.ch == CH_W'(c));
      tx_inc[c] = push & ~push_desc.rwn & (push_desc.ch == CH_W'(c));
      rx_dec[c] = pop  & head.rwn       & (head.ch == CH_W'(c));
      tx_dec[c] = pop  & ~head.rwn      & (head.ch == CH_W'(c));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CH; c++) begin
        rx_pend_q[c] <= '0;
        tx_pend_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        if (flush) begin
          rx_pend_q[c] <= '0;
          tx_pend_q[c] <= '0;
        end else begin
          if (rx_inc[c] && !rx_dec[c])      rx_pend_q[c] <= rx_pend_q[c] + CNT_W'(1);
          else if (rx_dec[c] && !rx_inc[c]) rx_pend_q[c] <= rx_pend_q[c] - CNT_W'(1);
          if (tx_inc[c] && !tx_dec[c])      tx_pend_q[c] <= tx_pend_q[c] + CNT_W'(1);
          else if (tx_dec[c] && !tx_inc[c]) tx_pend_q[c] <= tx_pend_q[c] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_clr_q <= '0;
      tx_clr_q <= '0;
    end else begin
      rx_clr_q <= '0;
      tx_clr_q <= '0;
      if (rx_cfg_wr && cfg_data_i[5]) rx_clr_q[ch_idx] <= 1'b1;
      if (tx_cfg_wr && cfg_data_i[5]) tx_clr_q[ch_idx] <= 1'b1;
    end
  end

  always_comb begin
    cfg_data_o = '0;
    if (cfg_valid_i) begin
      case (reg_off)
        REG_HYPER_CFG: cfg_data_o = {16'h0, hyper_cfg_q};
        REG_STATUS: begin
          cfg_data_o[31]      = ovf_q;
          cfg_data_o[CNT_W:1] = count_q;
          cfg_data_o[0]       = busy_i;
        end
        default: begin
          if (ch_ok) begin
            case (reg_off)
              REG_RX_SADDR:   cfg_data_o = 32'(rx_saddr_q[ch_idx]);
              REG_RX_SIZE:    cfg_data_o = 32'(rx_size_q[ch_idx]);
              REG_RXCFG:      cfg_data_o[5] = (rx_pend_q[ch_idx] != '0);
              REG_TX_SADDR:   cfg_data_o = 32'(tx_saddr_q[ch_idx]);
              REG_TX_SIZE:    cfg_data_o = 32'(tx_size_q[ch_idx]);
              REG_TXCFG:      cfg_data_o[5] = (tx_pend_q[ch_idx] != '0);
              REG_CA_SETUP:   cfg_data_o = 32'(ca_setup_q[ch_idx]);
              REG_HYPER_ADDR: cfg_data_o = hyper_addr_q[ch_idx];
              REG_EXT_ACT:    cfg_data_o = 32'(ext_act_q[ch_idx]);
              REG_EXT_CNT:    cfg_data_o = 32'(ext_cnt_q[ch_idx]);
              REG_EXT_STR:    cfg_data_o = 32'(ext_str_q[ch_idx]);
              REG_L2_ACT:     cfg_data_o = 32'(l2_act_q[ch_idx]);
              REG_L2_CNT:     cfg_data_o = 32'(l2_cnt_q[ch_idx]);
              REG_L2_STR:     cfg_data_o = 32'(l2_str_q[ch_idx]);
              default:        cfg_data_o = '0;
            endcase
          end
        end
      endcase
    end
  end

  assign cfg_ready_o        = 1'b1;
  assign cfg_rx_clr_o       = rx_clr_q;
  assign cfg_tx_clr_o       = tx_clr_q;
  assign cfg_hyper_intreg_o = hyper_cfg_q;
  assign trans_valid_o      = valid_q;
  assign trans_ch_o         = head.ch;
  assign trans_rwn_o        = head.rwn;
  assign trans_addr_space_o = head.space;
  assign trans_burst_o      = head.burst;
  assign trans_hyper_addr_o = head.haddr;
  assign trans_l2_addr_o    = head.l2;
  assign trans_size_o       = head.size;
  assign trans_twd_o        = head.twd;

endmodule

// File: tb/tb_udma_hyper_cfg_queue.sv
// Bench for udma_hyper_cfg_queue: directed scenarios then randomized traffic,
// all checked against a queue-based reference model of the register bank and FIFO.
module tb_udma_hyper_cfg_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] cfg_data_i = '0;
  logic [5:0]  cfg_addr_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_reg_rwn_i = 1'b1;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;
  logic [1:0]  cfg_rx_clr_o, cfg_tx_clr_o;
  logic [15:0] cfg_hyper_intreg_o;
  logic        trans_valid_o;
  logic        trans_ready_i = 1'b0;
  logic [0:0]  trans_ch_o;
  logic        trans_rwn_o, trans_addr_space_o, trans_burst_o;
  logic [31:0] trans_hyper_addr_o;
  logic [11:0] trans_l2_addr_o;
  logic [15:0] trans_size_o;
  logic [65:0] trans_twd_o;
  logic        busy_i = 1'b0;

  always #5 clk_i = ~clk_i;

  udma_hyper_cfg_queue #(
    .L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .NB_CH(2), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
    .cfg_reg_rwn_i(cfg_reg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .cfg_rx_clr_o(cfg_rx_clr_o), .cfg_tx_clr_o(cfg_tx_clr_o),
    .cfg_hyper_intreg_o(cfg_hyper_intreg_o),
    .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_ch_o(trans_ch_o),
    .trans_rwn_o(trans_rwn_o), .trans_addr_space_o(trans_addr_space_o),
    .trans_burst_o(trans_burst_o), .trans_hyper_addr_o(trans_hyper_addr_o),
    .trans_l2_addr_o(trans_l2_addr_o), .trans_size_o(trans_size_o),
    .trans_twd_o(trans_twd_o), .busy_i(busy_i)
  );

  // Reference model: register words per channel/offset and a queue of packed descriptors
  logic [31:0]  mreg [2][16];
  logic [15:0]  m_hcfg;
  logic         m_ovf;
  logic [129:0] mq [$];
  logic [1:0]   exp_rx_clr, exp_tx_clr;
  logic         busy_val = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic logic [31:0] regMask(input int off);
    case (off)
      0, 3:                 return 32'h0000_0FFF;
      1, 4, 11, 12, 14, 15: return 32'h0000_FFFF;
      6:                    return 32'h0000_0003;
      7:                    return 32'hFFFF_FFFF;
      10, 13:               return 32'h0000_0001;
      default:              return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 2; c++)
      for (int o = 0; o < 16; o++) mreg[c][o] = '0;
    mreg[0][6] = 32'h1;
    mreg[1][6] = 32'h1;
    m_hcfg = '0;
    m_ovf = 1'b0;
    mq.delete();
    exp_rx_clr = '0;
    exp_tx_clr = '0;
  endtask

  function automatic int pendCount(input int ch, input logic rwn);
    int n = 0;
    foreach (mq[i]) begin
      logic [129:0] d = mq[i];
      if (int'(d[129]) == ch && d[128] == rwn) n++;
    end
    return n;
  endfunction

  function automatic logic [129:0] buildDesc(input int ch, input logic rwn);
    return {1'(ch), rwn, mreg[ch][6][1], mreg[ch][6][0], mreg[ch][7],
            rwn ? mreg[ch][0][11:0] : mreg[ch][3][11:0],
            rwn ? mreg[ch][1][15:0] : mreg[ch][4][15:0],
            mreg[ch][10][0], mreg[ch][11][15:0], mreg[ch][12][15:0],
            mreg[ch][13][0], mreg[ch][14][15:0], mreg[ch][15][15:0]};
  endfunction

  function automatic logic [31:0] modelRead();
    int off = int'(cfg_addr_i[4:0]);
    int ch  = int'(cfg_addr_i[5]);
    logic [2:0] cnt = 3'(mq.size());
    if (!cfg_valid_i) return 32'h0;
    case (off)
      8:       return {16'h0, m_hcfg};
      9:       return {m_ovf, 27'h0, cnt, busy_i};
      2:       return (pendCount(ch, 1'b1) != 0) ? 32'h20 : 32'h0;
      5:       return (pendCount(ch, 1'b0) != 0) ? 32'h20 : 32'h0;
      default: return (off < 16) ? mreg[ch][off] : 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    if (!(cfg_valid_i && !cfg_reg_rwn_i)) checkOutput("rdata", 160'(cfg_data_o), 160'(modelRead()));
    checkOutput("cfg_ready", 160'(cfg_ready_o), 160'(1'b1));
    checkOutput("valid", 160'(trans_valid_o), 160'(mq.size() != 0));
    if (mq.size() != 0)
      checkOutput("head", 160'({trans_ch_o, trans_rwn_o, trans_addr_space_o, trans_burst_o,
                               trans_hyper_addr_o, trans_l2_addr_o, trans_size_o, trans_twd_o}),
                  160'(mq[0]));
    checkOutput("rx_clr", 160'(cfg_rx_clr_o), 160'(exp_rx_clr));
    checkOutput("tx_clr", 160'(cfg_tx_clr_o), 160'(exp_tx_clr));
    checkOutput("intreg", 160'(cfg_hyper_intreg_o), 160'(m_hcfg));
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled
  task automatic modelStep();
    int off = int'(cfg_addr_i[4:0]);
    int ch  = int'(cfg_addr_i[5]);
    logic wr = cfg_valid_i && !cfg_reg_rwn_i;
    logic kick = 1'b0;
    logic popped = (mq.size() != 0) && trans_ready_i;
    logic [129:0] d = '0;
    logic [1:0] rxc = '0, txc = '0;
    if (wr && (off == 2 || off == 5)) begin
      if (cfg_data_i[5]) begin
        if (off == 2) rxc[ch] = 1'b1;
        else          txc[ch] = 1'b1;
      end
      if (cfg_data_i[4]) begin
        kick = 1'b1;
        d = buildDesc(ch, off == 2);
      end
    end
    if (wr && off == 9 && cfg_data_i[30]) mq.delete();
    else begin
      if (popped) void'(mq.pop_front());
      if (kick) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    if (wr && off == 9 && cfg_data_i[31]) m_ovf = 1'b0;
    if (wr && off < 16 && regMask(off) != 0) mreg[ch][off] = cfg_data_i & regMask(off);
    if (wr && off == 8) m_hcfg = cfg_data_i[15:0];
    exp_rx_clr = rxc;
    exp_tx_clr = txc;
  endtask

  task automatic applyStimulus(input logic v, input logic rwn, input logic [5:0] addr,
                               input logic [31:0] data, input logic rdy);
    cfg_valid_i = v;
    cfg_reg_rwn_i = rwn;
    cfg_addr_i = addr;
    cfg_data_i = data;
    trans_ready_i = rdy;
    busy_i = busy_val;
    #1 checkAll();
    @(posedge clk_i);
    modelStep();
    @(negedge clk_i);
  endtask

  task automatic readCheck(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    cfg_valid_i = 1'b1;
    cfg_reg_rwn_i = 1'b1;
    cfg_addr_i = addr;
    cfg_data_i = '0;
    trans_ready_i = 1'b0;
    busy_i = busy_val;
    #1 checkOutput(tag, 160'(cfg_data_o), 160'(exp));
    applyStimulus(1'b1, 1'b1, addr, 32'h0, 1'b0);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_valid", 160'(trans_valid_o), 160'(1'b0));
    checkOutput("rst_clr", 160'({cfg_rx_clr_o, cfg_tx_clr_o}), 160'(4'h0));
    checkOutput("rst_rdata", 160'(cfg_data_o), 160'(32'h0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    readCheck("rst_ca_setup", 6'h26, 32'h1);
    readCheck("rst_status", 6'h09, 32'h0);

    $display("[TB] directed: ch1 RX kick");
    applyStimulus(1'b1, 1'b0, 6'h20, 32'h100, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h21, 32'h40, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h27, 32'h8000, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h22, 32'h10, 1'b0);
    checkOutput("kick_valid", 160'(trans_valid_o), 160'(1'b1));
    checkOutput("kick_ch", 160'(trans_ch_o), 160'(1'b1));
    checkOutput("kick_rwn", 160'(trans_rwn_o), 160'(1'b1));
    checkOutput("kick_l2", 160'(trans_l2_addr_o), 160'(12'h100));
    checkOutput("kick_size", 160'(trans_size_o), 160'(16'h40));
    checkOutput("kick_haddr", 160'(trans_hyper_addr_o), 160'(32'h8000));

    $display("[TB] directed: overflow");
    repeat (4) applyStimulus(1'b1, 1'b0, 6'h22, 32'h10, 1'b0);
    readCheck("ovf_set", 6'h09, 32'h8000_0008);
    applyStimulus(1'b1, 1'b0, 6'h09, 32'h8000_0000, 1'b0);
    readCheck("ovf_clear", 6'h09, 32'h0000_0008);

    $display("[TB] directed: full FIFO kick with pop");
    applyStimulus(1'b1, 1'b0, 6'h05, 32'h10, 1'b1);
    readCheck("full_kick", 6'h09, 32'h0000_0008);

    $display("[TB] directed: flush with pop");
    applyStimulus(1'b1, 1'b0, 6'h09, 32'h4000_0000, 1'b1);
    checkOutput("flush_valid", 160'(trans_valid_o), 160'(1'b0));
    readCheck("flush_count", 6'h09, 32'h0);
    readCheck("flush_rxpend", 6'h22, 32'h0);
    readCheck("flush_txpend", 6'h05, 32'h0);

    $display("[TB] directed: pend tracking");
    applyStimulus(1'b1, 1'b0, 6'h03, 32'h2AB, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h04, 32'h10, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 6'h05, 32'h10, 1'b0);
    readCheck("pend_tx_set", 6'h05, 32'h20);
    repeat (2) applyStimulus(1'b1, 1'b1, 6'h10, 32'h0, 1'b1);
    readCheck("pend_tx_clear", 6'h05, 32'h0);

    $display("[TB] directed: clear pulse and reset mid-queue");
    applyStimulus(1'b1, 1'b0, 6'h08, 32'hABCD_1234, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h02, 32'h30, 1'b0);
    checkOutput("clr_pulse", 160'(cfg_rx_clr_o), 160'(2'b01));
    checkOutput("clr_push", 160'(trans_valid_o), 160'(1'b1));
    applyStimulus(1'b1, 1'b0, 6'h25, 32'h10, 1'b0);
    checkOutput("clr_once", 160'(cfg_rx_clr_o), 160'(2'b00));
    cfg_valid_i = 1'b1;
    cfg_reg_rwn_i = 1'b1;
    cfg_addr_i = 6'h09;
    trans_ready_i = 1'b0;
    busy_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 160'(trans_valid_o), 160'(1'b0));
    checkOutput("rst_mid_clr", 160'({cfg_rx_clr_o, cfg_tx_clr_o}), 160'(4'h0));
    checkOutput("rst_mid_intreg", 160'(cfg_hyper_intreg_o), 160'(16'h0));
    checkOutput("rst_mid_status", 160'(cfg_data_o), 160'(32'h0));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    modelReset();

    $display("[TB] randomized traffic");
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 700; n++) begin
        logic v, rwn, rdy;
        logic [31:0] d;
        int off, ch;
        v = ($urandom % 5) != 0;
        rwn = ($urandom % 3) == 0;
        off = (($urandom % 10) < 3) ? ((($urandom % 2) != 0) ? 2 : 5) : int'($urandom_range(0, 17));
        ch = int'($urandom % 2);
        d = $urandom;
        if (off == 9) d[30] = ($urandom % 12) == 0;
        case (p)
          0:       rdy = ($urandom % 4) == 0;
          1:       rdy = ($urandom % 4) != 0;
          2:       rdy = ($urandom % 2) == 0;
          default: rdy = ($urandom % 8) == 0;
        endcase
        busy_val = 1'($urandom % 2);
        applyStimulus(v, rwn, {1'(ch), 5'(off)}, d, rdy);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
